// File: rtl/i2c_slave_responder.sv
// ---------------------------------------------------------------------------
// i2c_slave_responder
//
// I2C target (responder). The block detects START/STOP, matches a 7-bit
// address, ACKs and captures write bytes, and serves read bytes supplied by
// the host logic. SDA is open-drain: the block only ever pulls SDA low through
// sda_oe. It never drives SCL and never stretches the clock.
//
// Parameters
//   SLAVE_ADDR   7-bit device address, compared against address byte [7:1]
//   SYNC_STAGES  number of flops in the scl_i/sda_i synchronizers (>= 2)
//
// Ports
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   scl_i     in   sampled SCL line
//   sda_i     in   sampled SDA line
//   sda_oe    out  1 = pull SDA low, 0 = release
//   tx_data   in   byte returned to the master on a read, sampled on tx_req
//   tx_req    out  1-cycle pulse: tx_data loaded into the shift register
//   rx_data   out  last byte written by the master
//   rx_valid  out  1-cycle pulse: rx_data updated
//   rw        out  R/W bit of the last matched address (1 = read)
//   busy      out  1 from a matched address until STOP, NACK or mismatch
// ---------------------------------------------------------------------------
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rw,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WRITE,
        S_WRITE_ACK,
        S_READ,
        S_READ_ACK
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_p0;
    logic                   sda_p0;
    logic                   scl_p1;
    logic                   sda_p1;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift;

    // ---- Stage p0: synchronizers (idle bus level is high) ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
        end
    end

    assign scl_p0 = scl_sync[SYNC_STAGES-1];
    assign sda_p0 = sda_sync[SYNC_STAGES-1];

    // ---- Stage p1: one-cycle history for edge detection ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_p1 <= 1'b1;
            sda_p1 <= 1'b1;
        end else begin
            scl_p1 <= scl_p0;
            sda_p1 <= sda_p0;
        end
    end

    assign scl_rise  = scl_p0 & ~scl_p1;
    assign scl_fall  = ~scl_p0 & scl_p1;
    // SDA moving while SCL is stably high is a bus condition, not data.
    assign start_det = scl_p0 & scl_p1 & sda_p1 & ~sda_p0;
    assign stop_det  = scl_p0 & scl_p1 & ~sda_p1 & sda_p0;

    // ---- Stage p2: protocol FSM with registered outputs ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            sda_oe   <= 1'b0;
            tx_req   <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
            rw       <= 1'b0;
            busy     <= 1'b0;
            bit_cnt  <= 3'd0;
            shift    <= 8'h00;
        end else begin
            tx_req   <= 1'b0;
            rx_valid <= 1'b0;

            if (start_det) begin
                // Also covers a repeated START; busy is kept until the new
                // address either matches or not.
                state   <= S_ADDR;
                bit_cnt <= 3'd0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state  <= S_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                    end

                    S_ADDR: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_p0};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                // Address sits in the seven bits already shifted in.
                                if (shift[6:0] == SLAVE_ADDR) begin
                                    rw    <= sda_p0;
                                    busy  <= 1'b1;
                                    state <= S_ADDR_ACK;
                                end else begin
                                    busy  <= 1'b0;
                                    state <= S_IDLE;
                                end
                            end
                        end
                    end

                    S_ADDR_ACK: begin
                        // First fall asserts ACK, second fall ends the ACK bit.
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else if (rw) begin
                                shift   <= {tx_data[6:0], 1'b0};
                                tx_req  <= 1'b1;
                                sda_oe  <= ~tx_data[7];
                                bit_cnt <= 3'd0;
                                state   <= S_READ;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= S_WRITE;
                            end
                        end
                    end

                    S_WRITE: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_p0};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data  <= {shift[6:0], sda_p0};
                                rx_valid <= 1'b1;
                                state    <= S_WRITE_ACK;
                            end
                        end
                    end

                    S_WRITE_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= S_WRITE;
                            end
                        end
                    end

                    S_READ: begin
                        // bit7 went out on load; falls 1..7 send bits 6..0,
                        // the eighth fall ends bit 0 and frees SDA for the master.
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 3'd0;
                                state   <= S_READ_ACK;
                            end else begin
                                sda_oe  <= ~shift[7];
                                shift   <= {shift[6:0], 1'b0};
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end

                    S_READ_ACK: begin
                        if (scl_rise) begin
                            if (sda_p0) begin
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end
                        end else if (scl_fall) begin
                            // Only reachable after an ACK on the preceding rise.
                            shift   <= {tx_data[6:0], 1'b0};
                            tx_req  <= 1'b1;
                            sda_oe  <= ~tx_data[7];
                            bit_cnt <= 3'd0;
                            state   <= S_READ;
                        end
                    end

                    default: begin
                        state  <= S_IDLE;
                        sda_oe <= 1'b0;
                        busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_responder
//
// Bit-banged I2C master driving i2c_slave_responder over an open-drain SDA.
// Expected write bytes and read-load events are queued when stimulus is
// issued; a monitor pops and compares them whenever rx_valid / tx_req pulse.
// ---------------------------------------------------------------------------
module tb_i2c_slave_responder;

    localparam int Q = 25;  // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rw;
    logic       busy;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    logic       oe_seen = 1'b0;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave_responder #(
        .SLAVE_ADDR (7'h50),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .scl_i   (scl_m),
        .sda_i   (sda_bus),
        .sda_oe  (sda_oe),
        .tx_data (tx_data),
        .tx_req  (tx_req),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rw      (rw),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [7:0] e;
        if (sda_oe) oe_seen = 1'b1;
        if (rx_valid) begin
            if (exp_rx.size() == 0) begin
                check("rx_valid_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_rx.pop_front();
                check("rx_data", {24'd0, rx_data}, {24'd0, e});
            end
            check("rx_valid_busy", {31'd0, busy}, 32'd1);
            check("rx_tx_exclusive", {31'd0, tx_req}, 32'd0);
        end
        if (tx_req) begin
            if (exp_tx.size() == 0) begin
                check("tx_req_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_tx.pop_front();
                check("tx_req_rw", {31'd0, rw}, 32'd1);
            end
            check("tx_req_busy", {31'd0, busy}, 32'd1);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(Q); sda_m = 1'b0;
        wait_clk(Q); scl_m = 1'b1;
        wait_clk(Q); sda_m = 1'b1;
        wait_clk(2 * Q);
    endtask

    task automatic write_bit(input logic b);
        wait_clk(Q); sda_m = b;
        wait_clk(Q); scl_m = 1'b1;
        wait_clk(2 * Q); scl_m = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        wait_clk(Q); sda_m = 1'b1;
        wait_clk(Q); scl_m = 1'b1;
        wait_clk(Q); b = sda_bus;
        wait_clk(Q); scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;

        // Reset state
        wait_clk(5);
        check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_tx_req", {31'd0, tx_req}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rw", {31'd0, rw}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'h00);
        reset = 1'b0;
        wait_clk(10);

        // 1: write 0x3C to 0x50
        exp_rx.push_back(8'h3C);
        i2c_start();
        write_byte(8'hA0, ack);
        check("t1_addr_ack", {31'd0, ack}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd1);
        write_byte(8'h3C, ack);
        check("t1_data_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        check("t1_busy_after_stop", {31'd0, busy}, 32'd0);
        check("t1_rw", {31'd0, rw}, 32'd0);
        check("t1_rx_data", {24'd0, rx_data}, 32'h3C);

        // 2: address mismatch 0x51
        oe_seen = 1'b0;
        i2c_start();
        write_byte(8'hA2, ack);
        check("t2_addr_nack", {31'd0, ack}, 32'd1);
        check("t2_busy", {31'd0, busy}, 32'd0);
        write_byte(8'hFF, ack);
        check("t2_data_nack", {31'd0, ack}, 32'd1);
        i2c_stop();
        check("t2_oe_never", {31'd0, oe_seen}, 32'd0);
        check("t2_busy_after", {31'd0, busy}, 32'd0);

        // 3: read 0x96 (ACK) then 0x5A (NACK)
        tx_data = 8'h96;
        exp_tx.push_back(8'h96);
        i2c_start();
        write_byte(8'hA1, ack);
        check("t3_addr_ack", {31'd0, ack}, 32'd0);
        check("t3_rw", {31'd0, rw}, 32'd1);
        read_byte(rd);
        check("t3_rd0", {24'd0, rd}, 32'h96);
        tx_data = 8'h5A;
        exp_tx.push_back(8'h5A);
        write_bit(1'b0);
        read_byte(rd);
        check("t3_rd1", {24'd0, rd}, 32'h5A);
        write_bit(1'b1);
        check("t3_busy_after_nack", {31'd0, busy}, 32'd0);
        check("t3_oe_after_nack", {31'd0, sda_oe}, 32'd0);
        i2c_stop();

        // 4: write 0x11, repeated START, read 0xC3
        exp_rx.push_back(8'h11);
        i2c_start();
        write_byte(8'hA0, ack);
        check("t4_addr_w_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h11, ack);
        check("t4_data_ack", {31'd0, ack}, 32'd0);
        tx_data = 8'hC3;
        exp_tx.push_back(8'hC3);
        i2c_start();
        check("t4_busy_rstart", {31'd0, busy}, 32'd1);
        write_byte(8'hA1, ack);
        check("t4_addr_r_ack", {31'd0, ack}, 32'd0);
        read_byte(rd);
        check("t4_rd", {24'd0, rd}, 32'hC3);
        write_bit(1'b1);
        i2c_stop();
        check("t4_rx_data", {24'd0, rx_data}, 32'h11);
        check("t4_rw", {31'd0, rw}, 32'd1);

        // 5: asynchronous reset while driving a read 0-bit
        tx_data = 8'h00;
        exp_tx.push_back(8'h00);
        i2c_start();
        write_byte(8'hA1, ack);
        check("t5_addr_ack", {31'd0, ack}, 32'd0);
        wait_clk(10);
        check("t5_oe_before", {31'd0, sda_oe}, 32'd1);
        reset = 1'b1;
        #1;
        check("t5_oe_async", {31'd0, sda_oe}, 32'd0);
        check("t5_busy_async", {31'd0, busy}, 32'd0);
        wait_clk(3);
        reset = 1'b0;
        check("t5_rx_reset", {24'd0, rx_data}, 32'h00);
        sda_m = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(2 * Q);
        exp_rx.push_back(8'h5A);
        i2c_start();
        write_byte(8'hA0, ack);
        check("t5_rec_addr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h5A, ack);
        check("t5_rec_data_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        check("t5_rec_rx_data", {24'd0, rx_data}, 32'h5A);

        // 6: STOP in the middle of a write byte
        i2c_start();
        write_byte(8'hA0, ack);
        check("t6_addr_ack", {31'd0, ack}, 32'd0);
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        write_bit(1'b0);
        i2c_stop();
        check("t6_rx_data", {24'd0, rx_data}, 32'h5A);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_sda_oe", {31'd0, sda_oe}, 32'd0);

        wait_clk(20);
        check("rx_queue_drained", exp_rx.size(), 32'd0);
        check("tx_queue_drained", exp_tx.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
